// File: rtl/detector_pkg.sv
// Types and constants shared by the serial pattern detector and its input serializer.
package detector_pkg;

    typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;

    // Word width used by both the serializer and the detector-side benches.
    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serializador_de_entrada.sv
// Parallel-to-serial front end for the pattern detector: accepts words over valid/ready
// and emits them one bit per clock on x, back-to-back with no idle gap between words.
module serializador_de_entrada
    import detector_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             x,
    output logic             x_valid,
    output logic             word_start
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             x_nxt, x_valid_nxt, word_start_nxt;
    logic             last_bit, accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // cnt tracks the index of the bit currently on x, so the last bit is when cnt hits WIDTH-1.
    assign last_bit  = (state == SER_SHIFT) && (cnt == LAST_IDX);
    assign ready_out = (state == SER_IDLE) || last_bit;
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SER_IDLE:  if (accept) state_nxt = SER_SHIFT;
            SER_SHIFT: if (last_bit && !accept) state_nxt = SER_IDLE;
            default:   state_nxt = SER_IDLE;
        endcase
    end

    // The first bit of a freshly loaded word goes straight to x; the shift register keeps the rest.
    always_comb begin
        cnt_nxt        = cnt;
        shreg_nxt      = shreg;
        x_nxt          = 1'b0;
        x_valid_nxt    = 1'b0;
        word_start_nxt = 1'b0;
        if (accept) begin
            cnt_nxt        = '0;
            shreg_nxt      = drop_first(data_in);
            x_nxt          = first_bit(data_in);
            x_valid_nxt    = 1'b1;
            word_start_nxt = 1'b1;
        end else if ((state == SER_SHIFT) && !last_bit) begin
            cnt_nxt     = cnt + CNT_W'(1);
            shreg_nxt   = drop_first(shreg);
            x_nxt       = first_bit(shreg);
            x_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            shreg      <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            word_start <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            x          <= x_nxt;
            x_valid    <= x_valid_nxt;
            word_start <= word_start_nxt;
        end
    end

endmodule

// File: tb/tb_serializador_de_entrada.sv
// Scoreboard bench for the input serializer: MSB-first, LSB-first and single-bit instances.
module tb_serializador_de_entrada;

    typedef struct packed {
        logic x;
        logic ws;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic [0:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, ready_b, ready_c;
    logic       x_a, x_b, x_c;
    logic       xv_a, xv_b, xv_c;
    logic       ws_a, ws_b, ws_c;
    logic       mon_en;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t ea, eb, ec;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serializador_de_entrada #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clock(clk), .reset(rst), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .x(x_a), .x_valid(xv_a), .word_start(ws_a)
    );

    serializador_de_entrada #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clock(clk), .reset(rst), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .x(x_b), .x_valid(xv_b), .word_start(ws_b)
    );

    serializador_de_entrada #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_c (
        .clock(clk), .reset(rst), .data_in(data_c), .valid_in(valid_c),
        .ready_out(ready_c), .x(x_c), .x_valid(xv_c), .word_start(ws_c)
    );

    task automatic cmp(input string nm, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, req);
        end
    endtask

    task automatic unexpected(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t: x_valid high with no expected bit queued", nm, $time);
    endtask

    // Monitors: pop one expected bit whenever x_valid is high, otherwise demand a quiet line.
    always @(negedge clk) if (mon_en) begin
        if (xv_a) begin
            if (q_a.size() == 0) unexpected("a_extra_bit");
            else begin
                ea = q_a.pop_front();
                cmp("a_x", x_a, ea.x);
                cmp("a_word_start", ws_a, ea.ws);
            end
        end else begin
            cmp("a_idle_x", x_a, 1'b0);
            cmp("a_idle_word_start", ws_a, 1'b0);
        end
    end

    always @(negedge clk) if (mon_en) begin
        if (xv_b) begin
            if (q_b.size() == 0) unexpected("b_extra_bit");
            else begin
                eb = q_b.pop_front();
                cmp("b_x", x_b, eb.x);
                cmp("b_word_start", ws_b, eb.ws);
            end
        end else begin
            cmp("b_idle_x", x_b, 1'b0);
            cmp("b_idle_word_start", ws_b, 1'b0);
        end
    end

    always @(negedge clk) if (mon_en) begin
        if (xv_c) begin
            if (q_c.size() == 0) unexpected("c_extra_bit");
            else begin
                ec = q_c.pop_front();
                cmp("c_x", x_c, ec.x);
                cmp("c_word_start", ws_c, ec.ws);
            end
        end else begin
            cmp("c_idle_x", x_c, 1'b0);
            cmp("c_idle_word_start", ws_c, 1'b0);
        end
    end

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic send_a(input logic [7:0] w, input logic [7:0] bits, input int npush);
        int t;
        data_a  = w;
        valid_a = 1'b1;
        t = 0;
        while (!ready_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready_a) begin
            n_vec++;
            n_err++;
            $display("FAIL a_ready_timeout: ready_out stayed 0, expected 1 within 100 cycles");
        end else begin
            for (int i = 0; i < npush; i++) q_a.push_back({bits[7-i], (i == 0)});
        end
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w, input logic [7:0] bits);
        int t;
        data_b  = w;
        valid_b = 1'b1;
        t = 0;
        while (!ready_b && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready_b) begin
            n_vec++;
            n_err++;
            $display("FAIL b_ready_timeout: ready_out stayed 0, expected 1 within 100 cycles");
        end else begin
            for (int i = 0; i < 8; i++) q_b.push_back({bits[7-i], (i == 0)});
        end
        @(negedge clk);
        valid_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] c_bits;
        rst     = 1'b1;
        mon_en  = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a  = '0;   data_b  = '0;   data_c  = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Quiet line after reset
        for (int i = 0; i < 10; i++) begin
            cmp("t1_ready_a", ready_a, 1'b1);
            cmp("t1_ready_b", ready_b, 1'b1);
            cmp("t1_ready_c", ready_c, 1'b1);
            @(negedge clk);
        end

        // Single word, MSB first, ready low until the last bit
        send_a(8'hD0, 8'b11010000, 8);
        for (int i = 0; i < 8; i++) begin
            cmp("t2_ready", ready_a, (i == 7));
            @(negedge clk);
        end
        cmp("t2_idle_valid", xv_a, 1'b0);
        repeat (2) @(negedge clk);

        // Back-to-back words with no gap
        send_a(8'hD0, 8'b11010000, 8);
        send_a(8'h0D, 8'b00001101, 8);
        for (int i = 0; i < 9; i++) begin
            cmp("t3_contiguous_valid", xv_a, (i < 8));
            @(negedge clk);
        end

        // LSB first
        send_b(8'h0B, 8'b11010000);
        repeat (9) @(negedge clk);

        // Reset while bit 4 is on x, with a competing valid_in that must be ignored
        send_a(8'hFF, 8'b11111111, 5);
        repeat (4) @(negedge clk);
        rst     = 1'b1;
        valid_a = 1'b1;
        data_a  = 8'hAA;
        @(negedge clk);
        rst     = 1'b0;
        valid_a = 1'b0;
        cmp("t5_after_reset_x", x_a, 1'b0);
        cmp("t5_after_reset_valid", xv_a, 1'b0);
        cmp("t5_after_reset_ready", ready_a, 1'b1);
        @(negedge clk);
        send_a(8'h80, 8'b10000000, 8);
        repeat (9) @(negedge clk);
        send_a(8'hA5, 8'b10100101, 8);
        repeat (9) @(negedge clk);

        // Single-bit words, one per cycle
        c_bits  = 4'b1011;
        valid_c = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            data_c = c_bits[i];
            cmp("t6_ready", ready_c, 1'b1);
            q_c.push_back({c_bits[i], 1'b1});
            @(negedge clk);
        end
        valid_c = 1'b0;
        repeat (3) @(negedge clk);

        cmp("end_queue_a_empty", (q_a.size() == 0), 1'b1);
        cmp("end_queue_b_empty", (q_b.size() == 0), 1'b1);
        cmp("end_queue_c_empty", (q_c.size() == 0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
